// File: rtl/reg_file_mp.sv
// Multi-port decode register file with same-cycle write bypass and a per-register busy scoreboard.
// Optional build macro REG_FILE_ZERO_R0_EN hardwires register 0 to zero.
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_rdy_o,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
  input  logic                       rsv_en_i,
  input  logic [ADDR_W-1:0]          rsv_addr_i,
  output logic [(1<<ADDR_W)-1:0]     busy_o
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef REG_FILE_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_nxt;
  logic [NUM_WR-1:0] wr_ok;
  logic              rsv_ok;

  // With a hardwired r0, writes and reservations to address 0 vanish here,
  // which also removes them from bypass and the scoreboard.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = wr_en_i[j] && !(ZERO_R0 && (wr_addr_i[j*ADDR_W +: ADDR_W] == '0));
    end
    rsv_ok = rsv_en_i && !(ZERO_R0 && (rsv_addr_i == '0));
  end

  // Later ports are assigned last, so the highest-index port wins a conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < DEPTH; n++) begin
        mem[n] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) begin
          mem[wr_addr_i[j*ADDR_W +: ADDR_W]] <= wr_data_i[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Reservation is applied after write-clears so a new producer keeps the register busy.
  always_comb begin
    busy_nxt = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_ok[j]) begin
        busy_nxt[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (rsv_ok) begin
      busy_nxt[rsv_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_o = busy_q;

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rv;
  logic              hit;

  always_comb begin
    rd_data_o = '0;
    rd_rdy_o  = '1;
    ra        = '0;
    rv        = '0;
    hit       = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra  = rd_addr_i[k*ADDR_W +: ADDR_W];
      rv  = mem[ra];
      hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == ra)) begin
          hit = 1'b1;
          rv  = wr_data_i[j*DATA_W +: DATA_W];
        end
      end
      // Writes are ignored under reset, so they must not leak through bypass either.
      if (reset) begin
        rv  = '0;
        hit = 1'b0;
      end
      rd_data_o[k*DATA_W +: DATA_W] = rv;
      rd_rdy_o[k] = hit || !busy_q[ra];
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic against an array model.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 1 << AW;
`ifdef REG_FILE_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_rdy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [DEPTH-1:0]  busy;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_rdy_o(rd_rdy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic bit wr_hits(input int j, input int a);
    return wr_en[j] && (int'(wr_addr[j*AW +: AW]) == a) && !(ZERO_R0 && a == 0);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int a);
    if (ZERO_R0 && a == 0) return '0;
    for (int j = NW - 1; j >= 0; j--) begin
      if (wr_hits(j, a)) return wr_data[j*DW +: DW];
    end
    return m_mem[a];
  endfunction

  function automatic logic exp_rdy(input int a);
    for (int j = 0; j < NW; j++) begin
      if (wr_hits(j, a)) return 1'b1;
    end
    return !m_busy[a];
  endfunction

  task automatic model_clear();
    for (int n = 0; n < DEPTH; n++) m_mem[n] = '0;
    m_busy = '0;
  endtask

  // Per-register view of one clock edge: reservation beats write-clear; highest write port wins storage.
  task automatic tick();
    logic [DW-1:0]    nm [DEPTH];
    logic [DEPTH-1:0] nb;
    @(posedge clk);
    for (int n = 0; n < DEPTH; n++) begin
      bit written;
      nm[n] = m_mem[n];
      nb[n] = m_busy[n];
      written = 1'b0;
      for (int j = NW - 1; j >= 0; j--) begin
        if (!written && wr_hits(j, n)) begin
          nm[n] = wr_data[j*DW +: DW];
          written = 1'b1;
        end
      end
      if (rsv_en && int'(rsv_addr) == n && !(ZERO_R0 && n == 0)) nb[n] = 1'b1;
      else if (written) nb[n] = 1'b0;
    end
    for (int n = 0; n < DEPTH; n++) m_mem[n] = nm[n];
    m_busy = nb;
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    rd_addr = '0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      for (int j = 0; j < NW; j++) begin
        wr_en[j] = 1'b1;
        wr_addr[j*AW +: AW] = AW'($urandom_range(1, DEPTH - 1));
        wr_data[j*DW +: DW] = $urandom;
      end
      rsv_en = 1'b1;
      rsv_addr = AW'($urandom_range(1, DEPTH - 1));
      rd_addr[0 +: AW] = wr_addr[0 +: AW];
      rd_addr[AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
      @(posedge clk);
      #3;
      for (int k = 0; k < NR; k++) begin
        checks++;
        if (rd_data[k*DW +: DW] !== '0) begin
          failures++;
          $display("FAIL reset_rd_data port%0d got=%h want=0", k, rd_data[k*DW +: DW]);
        end
      end
      checks++;
      if (rd_rdy !== '1) begin
        failures++;
        $display("FAIL reset_rd_rdy got=%b want=all1", rd_rdy);
      end
      checks++;
      if (busy !== '0) begin
        failures++;
        $display("FAIL reset_busy got=%h want=0", busy);
      end
    end
    idle();
    reset = 1'b0;
    rd_addr[0 +: AW] = AW'(5);
    rd_addr[AW +: AW] = AW'(7);
    #1;
    checks++;
    if (rd_data !== '0 || rd_rdy !== '1) begin
      failures++;
      $display("FAIL post_reset_read got data=%h rdy=%b want data=0 rdy=11", rd_data, rd_rdy);
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en[0] = 1'b1; wr_addr[0 +: AW] = AW'(3); wr_data[0 +: DW] = 32'hAAAA_AAAA;
    rd_addr[0 +: AW] = AW'(3);
    #2;
    checks++;
    if (rd_data[0 +: DW] !== 32'hAAAA_AAAA || rd_rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL bypass_same_cycle got data=%h rdy=%b want data=aaaaaaaa rdy=1", rd_data[0 +: DW], rd_rdy[0]);
    end
    tick();
    idle();
    #2;
    checks++;
    if (rd_data[0 +: DW] !== 32'hAAAA_AAAA) begin
      failures++;
      $display("FAIL bypass_storage got=%h want=aaaaaaaa", rd_data[0 +: DW]);
    end
  endtask

  task automatic test_write_conflict();
    idle();
    wr_en = '1;
    wr_addr[0 +: AW] = AW'(9); wr_data[0 +: DW] = 32'h11;
    wr_addr[AW +: AW] = AW'(9); wr_data[DW +: DW] = 32'h22;
    rd_addr[AW +: AW] = AW'(9);
    #2;
    checks++;
    if (rd_data[DW +: DW] !== 32'h22) begin
      failures++;
      $display("FAIL conflict_bypass got=%h want=22", rd_data[DW +: DW]);
    end
    tick();
    idle();
    #2;
    checks++;
    if (rd_data[DW +: DW] !== 32'h22) begin
      failures++;
      $display("FAIL conflict_storage got=%h want=22", rd_data[DW +: DW]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_addr = AW'(4);
    rd_addr[0 +: AW] = AW'(4);
    #2;
    checks++;
    if (busy[4] !== 1'b0 || rd_rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL rsv_before_edge got busy=%b rdy=%b want busy=0 rdy=1", busy[4], rd_rdy[0]);
    end
    tick();
    idle();
    #2;
    checks++;
    if (busy[4] !== 1'b1 || rd_rdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL rsv_busy got busy=%b rdy=%b want busy=1 rdy=0", busy[4], rd_rdy[0]);
    end
    wr_en[1] = 1'b1; wr_addr[AW +: AW] = AW'(4); wr_data[DW +: DW] = 32'h55;
    #1;
    checks++;
    if (rd_rdy[0] !== 1'b1 || rd_data[0 +: DW] !== 32'h55 || busy[4] !== 1'b1) begin
      failures++;
      $display("FAIL clear_write_cycle got rdy=%b data=%h busy=%b want rdy=1 data=55 busy=1", rd_rdy[0], rd_data[0 +: DW], busy[4]);
    end
    tick();
    idle();
    #2;
    checks++;
    if (busy[4] !== 1'b0 || rd_rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL clear_after got busy=%b rdy=%b want busy=0 rdy=1", busy[4], rd_rdy[0]);
    end
  endtask

  task automatic test_rsv_and_write();
    idle();
    rsv_en = 1'b1; rsv_addr = AW'(6);
    wr_en[0] = 1'b1; wr_addr[0 +: AW] = AW'(6); wr_data[0 +: DW] = 32'h1234_5678;
    tick();
    idle();
    rd_addr[0 +: AW] = AW'(6);
    #2;
    checks++;
    if (busy[6] !== 1'b1 || rd_data[0 +: DW] !== 32'h1234_5678 || rd_rdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL rsv_write_same got busy=%b data=%h rdy=%b want busy=1 data=12345678 rdy=0", busy[6], rd_data[0 +: DW], rd_rdy[0]);
    end
  endtask

  task automatic test_reg0();
    logic [DW-1:0] want_d;
    logic          want_b;
    logic          want_r;
    idle();
    wr_en[0] = 1'b1; wr_addr[0 +: AW] = '0; wr_data[0 +: DW] = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = '0;
    rd_addr[0 +: AW] = '0;
    #2;
    want_d = ZERO_R0 ? 32'h0 : 32'hFFFF_FFFF;
    checks++;
    if (rd_data[0 +: DW] !== want_d || rd_rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL reg0_same_cycle got data=%h rdy=%b want data=%h rdy=1", rd_data[0 +: DW], rd_rdy[0], want_d);
    end
    tick();
    idle();
    #2;
    want_b = ZERO_R0 ? 1'b0 : 1'b1;
    want_r = ~want_b;
    checks++;
    if (rd_data[0 +: DW] !== want_d || busy[0] !== want_b || rd_rdy[0] !== want_r) begin
      failures++;
      $display("FAIL reg0_after got data=%h busy=%b rdy=%b want data=%h busy=%b rdy=%b",
               rd_data[0 +: DW], busy[0], rd_rdy[0], want_d, want_b, want_r);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int j = 0; j < NW; j++) begin
        wr_en[j] = 1'($urandom_range(0, 1));
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[j*DW +: DW] = $urandom;
      end
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, 7));
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 1) == 1)
          rd_addr[k*AW +: AW] = wr_addr[$urandom_range(0, NW - 1)*AW +: AW];
        else
          rd_addr[k*AW +: AW] = AW'($urandom_range(0, 11));
      end
      #2;
      for (int k = 0; k < NR; k++) begin
        int a;
        a = int'(rd_addr[k*AW +: AW]);
        checks++;
        if (rd_data[k*DW +: DW] !== exp_data(a) || rd_rdy[k] !== exp_rdy(a)) begin
          failures++;
          $display("FAIL random_read cyc=%0d port%0d addr=%0d got data=%h rdy=%b want data=%h rdy=%b",
                   cyc, k, a, rd_data[k*DW +: DW], rd_rdy[k], exp_data(a), exp_rdy(a));
        end
      end
      checks++;
      if (busy !== m_busy) begin
        failures++;
        $display("FAIL random_busy cyc=%0d got=%h want=%h", cyc, busy, m_busy);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    idle();
    wr_en = '1;
    wr_addr[0 +: AW] = AW'(2); wr_data[0 +: DW] = 32'hDEAD_BEEF;
    wr_addr[AW +: AW] = AW'(10); wr_data[DW +: DW] = 32'hCAFE_F00D;
    rsv_en = 1'b1; rsv_addr = AW'(3);
    rd_addr[0 +: AW] = AW'(9);
    rd_addr[AW +: AW] = AW'(10);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== '0 || rd_data !== '0 || rd_rdy !== '1) begin
      failures++;
      $display("FAIL mid_reset got busy=%h data=%h rdy=%b want busy=0 data=0 rdy=11", busy, rd_data, rd_rdy);
    end
    @(posedge clk);
    #1;
    model_clear();
    idle();
    reset = 1'b0;
    rd_addr[0 +: AW] = AW'(2);
    #1;
    checks++;
    if (rd_data !== '0 || busy !== '0) begin
      failures++;
      $display("FAIL after_mid_reset got data=%h busy=%h want data=0 busy=0", rd_data, busy);
    end
    wr_en[0] = 1'b1; wr_addr[0 +: AW] = AW'(10); wr_data[0 +: DW] = 32'h0BAD_CAFE;
    tick();
    idle();
    #2;
    checks++;
    if (rd_data[DW +: DW] !== 32'h0BAD_CAFE) begin
      failures++;
      $display("FAIL resume_write got=%h want=0badcafe", rd_data[DW +: DW]);
    end
  endtask

  initial begin
    idle();
    rd_addr = '0;
    test_reset();
    test_bypass();
    test_write_conflict();
    test_scoreboard();
    test_rsv_and_write();
    test_reg0();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
